// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor:
// default group size, add/sub mode encodings and saturation bounds.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Saturation bounds are returned 64 bits wide; callers keep the low WIDTH bits.
  function automatic logic [63:0] sat_max_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_group.sv
// GROUP-bit combinational carry-lookahead group: per-bit sum plus group
// generate/propagate for the slice-level carry chain.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] gi_s;
  logic [GROUP-1:0] pi_s;
  logic [GROUP-1:0] c_s;
  logic             carry_s;

  assign gi_s = a & b;
  assign pi_s = a | b;

  // in-group carries and group generate
  always_comb begin
    c_s     = {GROUP{1'b0}};
    g       = 1'b0;
    carry_s = cin;
    for (int i = 0; i < GROUP; i++) begin
      c_s[i]  = carry_s;
      carry_s = gi_s[i] | (pi_s[i] & carry_s);
      g       = gi_s[i] | (pi_s[i] & g);
    end
  end

  assign p   = &pi_s;
  assign sum = a ^ b ^ c_s;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES slice per stage,
// carry registered between slices, valid/ready handshake with full backpressure.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int GROUP  = CLA_GROUP,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / GROUP;
  localparam int LAST  = STAGES - 1;

  localparam logic [63:0]      MAX_POS_W = sat_max_pos(WIDTH);
  localparam logic [63:0]      MIN_NEG_W = sat_min_neg(WIDTH);
  localparam logic [WIDTH-1:0] MAX_POS   = MAX_POS_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_NEG   = MIN_NEG_W[WIDTH-1:0];

  if ((WIDTH % (STAGES * GROUP)) != 0) begin : g_param_check
    $fatal(1, "pipelined_cla_addsub: WIDTH must be a multiple of STAGES*GROUP");
  end

  logic [STAGES-1:0] valid_s;
  logic [STAGES-1:0] adv_s;

  // stage k advances when empty or when its successor advances
  always_comb begin
    adv_s       = {STAGES{1'b0}};
    adv_s[LAST] = !valid_s[LAST] || out_ready;
    for (int i = LAST - 1; i >= 0; i--) begin
      adv_s[i] = !valid_s[i] || adv_s[i+1];
    end
  end

  assign in_ready = adv_s[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Only the operand bits not yet consumed travel down the pipe.
    localparam int HI_W = WIDTH - k * SLICE;

    logic [HI_W-1:0]        a_src_s;
    logic [HI_W-1:0]        b_src_s;
    logic                   cin_s;
    logic                   sat_src_s;
    logic                   vld_src_s;
    logic [SLICE-1:0]       ssum_s;
    logic                   slice_cout_s;
    logic [(k+1)*SLICE-1:0] acc_sum_s;

    if (k == 0) begin : g_head
      assign a_src_s   = in_a;
      assign b_src_s   = (in_sub == MODE_ADD) ? in_b : ~in_b;
      assign cin_s     = (in_sub == MODE_SUB);
      assign sat_src_s = in_sat && (SAT_EN != 0);
      assign vld_src_s = in_valid;
      assign acc_sum_s = ssum_s;
    end else begin : g_body
      assign a_src_s   = g_stage[k-1].g_mid.a_r;
      assign b_src_s   = g_stage[k-1].g_mid.b_r;
      assign cin_s     = g_stage[k-1].g_mid.cy_r;
      assign sat_src_s = g_stage[k-1].g_mid.sat_r;
      assign vld_src_s = g_stage[k-1].g_mid.vld_r;
      assign acc_sum_s = {ssum_s, g_stage[k-1].g_mid.sum_r};
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      logic grp_cin_s;
      logic gg_s;
      logic gp_s;

      if (g == 0) begin : g_c0
        assign grp_cin_s = cin_s;
      end else begin : g_cn
        assign grp_cin_s = g_grp[g-1].gg_s | (g_grp[g-1].gp_s & g_grp[g-1].grp_cin_s);
      end

      cla_group #(.GROUP(GROUP)) u_grp (
        .a   (a_src_s[g*GROUP +: GROUP]),
        .b   (b_src_s[g*GROUP +: GROUP]),
        .cin (grp_cin_s),
        .sum (ssum_s[g*GROUP +: GROUP]),
        .g   (gg_s),
        .p   (gp_s)
      );
    end

    assign slice_cout_s = g_grp[NGRP-1].gg_s | (g_grp[NGRP-1].gp_s & g_grp[NGRP-1].grp_cin_s);

    if (k < LAST) begin : g_mid
      logic                   vld_r;
      logic                   cy_r;
      logic                   sat_r;
      logic [HI_W-SLICE-1:0]  a_r;
      logic [HI_W-SLICE-1:0]  b_r;
      logic [(k+1)*SLICE-1:0] sum_r;

      // intermediate stage register: finished low slices plus skewed upper operands
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_r <= 1'b0;
          cy_r  <= 1'b0;
          sat_r <= 1'b0;
          a_r   <= {(HI_W-SLICE){1'b0}};
          b_r   <= {(HI_W-SLICE){1'b0}};
          sum_r <= {((k+1)*SLICE){1'b0}};
        end else if (adv_s[k]) begin
          vld_r <= vld_src_s;
          if (vld_src_s) begin
            cy_r  <= slice_cout_s;
            sat_r <= sat_src_s;
            a_r   <= a_src_s[HI_W-1:SLICE];
            b_r   <= b_src_s[HI_W-1:SLICE];
            sum_r <= acc_sum_s;
          end
        end
      end

      assign valid_s[k] = vld_r;
    end else begin : g_tail
      logic             cmsb_s;
      logic             ovf_s;
      logic [WIDTH-1:0] res_s;

      // Carry into the MSB recovered from the MSB sum and its operand bits.
      assign cmsb_s = acc_sum_s[WIDTH-1] ^ a_src_s[HI_W-1] ^ b_src_s[HI_W-1];
      assign ovf_s  = cmsb_s ^ slice_cout_s;

      // clamp toward the sign of A on signed overflow
      always_comb begin
        res_s = acc_sum_s;
        if (sat_src_s && ovf_s) begin
          if (!a_src_s[HI_W-1]) begin
            res_s = MAX_POS;
          end else begin
            res_s = MIN_NEG;
          end
        end else begin
          res_s = acc_sum_s;
        end
      end

      // output register, held while the consumer stalls
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_sum   <= {WIDTH{1'b0}};
          out_cout  <= 1'b0;
          out_ovf   <= 1'b0;
        end else if (adv_s[k]) begin
          out_valid <= vld_src_s;
          if (vld_src_s) begin
            out_sum  <= res_s;
            out_cout <= slice_cout_s;
            out_ovf  <= ovf_s;
          end
        end
      end

      assign valid_s[k] = out_valid;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (WIDTH=16, STAGES=2, GROUP=4, SAT_EN=1).
module tb_pipelined_cla_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sub;
  logic        in_sat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  logic [17:0] sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        rand_bp  = 1'b0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(16), .STAGES(2), .GROUP(4), .SAT_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_sat    (in_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] pk(input logic ovf, input logic cout, input logic [15:0] sum);
    return {ovf, cout, sum};
  endfunction

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub, input logic sat);
    logic [15:0] bb;
    logic [16:0] full;
    logic [15:0] s;
    logic        ov;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
    s    = full[15:0];
    ov   = (a[15] == bb[15]) && (s[15] != a[15]);
    if (sat && ov) s = a[15] ? 16'h8000 : 16'h7FFF;
    return {ov, full[16], s};
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic sat, input logic [17:0] exp);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_sat   = sat;
    waited   = 0;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check_eq("send_accept", in_ready, 1);
    if (in_ready) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain", sb_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  // output monitor: a transfer happens on the next rising edge
  always @(negedge clk) begin
    logic [17:0] e;
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("no_stale", out_valid, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sum", out_sum, e[15:0]);
        check_eq("cout", out_cout, e[16]);
        check_eq("ovf", out_ovf, e[17]);
      end
    end
  end

  always @(negedge clk) begin
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic        rt;
    rst = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0;
    in_sub = 1'b0; in_sat = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sum", out_sum, 0);
    check_eq("rst_out_flags", {out_cout, out_ovf}, 0);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    // latency: visible in the second cycle after the accept cycle
    send(16'h1234, 16'h0FCD, 1'b0, 1'b0, pk(1'b0, 1'b0, 16'h2201));
    #2;
    check_eq("lat_early", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("lat_on", out_valid, 1);
    wait_drain();

    send(16'h00FF, 16'h0001, 1'b0, 1'b0, pk(1'b0, 1'b0, 16'h0100));
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, pk(1'b0, 1'b1, 16'h0000));
    send(16'h0000, 16'h0001, 1'b1, 1'b0, pk(1'b0, 1'b0, 16'hFFFF));
    send(16'h8000, 16'h0001, 1'b1, 1'b0, pk(1'b1, 1'b1, 16'h7FFF));
    send(16'h8000, 16'h0001, 1'b1, 1'b1, pk(1'b1, 1'b1, 16'h8000));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, pk(1'b1, 1'b0, 16'h8000));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, pk(1'b1, 1'b0, 16'h7FFF));
    wait_drain();

    // backpressure: two beats fill the pipe, third is refused
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h0001, 16'h0002, 1'b0, 1'b0, pk(1'b0, 1'b0, 16'h0003));
    send(16'h0100, 16'h0200, 1'b0, 1'b0, pk(1'b0, 1'b0, 16'h0300));
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'h0005; in_b = 16'h0003; in_sub = 1'b1; in_sat = 1'b0;
    #1;
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    check_eq("bp_hold0", out_sum, 16'h0003);
    repeat (3) @(negedge clk);
    #1;
    check_eq("bp_hold1", out_sum, 16'h0003);
    check_eq("bp_still_full", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(16'h0005, 16'h0003, 1'b1, 1'b0, pk(1'b0, 1'b1, 16'h0002));
    send(16'hF000, 16'h1000, 1'b0, 1'b0, pk(1'b0, 1'b1, 16'h0000));
    send(16'h4000, 16'h4000, 1'b0, 1'b1, pk(1'b1, 1'b0, 16'h7FFF));
    wait_drain();

    // random operands under random consumer stalls
    rand_bp = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      send(ra, rb, rs, rt, ref_model(ra, rb, rs, rt));
    end
    rand_bp = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();

    // asynchronous reset with two beats in flight
    send(16'h1111, 16'h1111, 1'b0, 1'b0, pk(1'b0, 1'b0, 16'h2222));
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0, pk(1'b0, 1'b0, 16'h1010));
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_out_sum", out_sum, 0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_idle", out_valid, 0);
    end
    send(16'h0002, 16'h0003, 1'b0, 1'b0, pk(1'b0, 1'b0, 16'h0005));
    #2;
    check_eq("post_rst_lat_early", out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("post_rst_lat_on", out_valid, 1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
